// File: rtl/multi_voice_sound.sv
// Multi-voice square-wave tone generator with per-voice note durations.
// All active voices are mixed into a single PWM audio output.
module multi_voice_sound #(
    parameter int unsigned NCH      = 4,
    parameter int unsigned PW       = 32,
    parameter int unsigned DW       = 16,
    parameter int unsigned TICK_DIV = 100000,
    parameter int unsigned PWM_BITS = 8,
    localparam int unsigned CW      = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           wr_en,
    input  logic [CW-1:0]  wr_ch,
    input  logic [PW-1:0]  wr_period,
    input  logic [DW-1:0]  wr_dur,
    output logic [NCH-1:0] busy,
    output logic [NCH-1:0] done,
    output logic           audPWM
);

    localparam int unsigned NB   = $clog2(NCH);
    localparam int unsigned LW   = NB + 1;
    localparam int unsigned CMPW = PWM_BITS + NB + 1;
    localparam int unsigned TW   = $clog2(TICK_DIV);

    typedef enum logic {
        IDLE = 1'b0,
        PLAY = 1'b1
    } voice_state_t;

    voice_state_t        state_q  [NCH];
    voice_state_t        state_d  [NCH];
    logic [PW-1:0]       period_q [NCH];
    logic [PW-1:0]       period_d [NCH];
    logic [PW-1:0]       phase_q  [NCH];
    logic [PW-1:0]       phase_d  [NCH];
    logic [DW-1:0]       dur_q    [NCH];
    logic [DW-1:0]       dur_d    [NCH];
    logic [NCH-1:0]      timed_q, timed_d;
    logic [NCH-1:0]      done_q, done_d;
    logic [NCH-1:0]      sq;
    logic [TW-1:0]       tick_cnt_q, tick_cnt_d;
    logic                tick;
    logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
    logic [LW-1:0]       level, level_q, level_d;
    logic                aud_q, aud_d;
    logic                wr_ok;

    // Square wave per voice and count of voices currently driving high.
    always_comb begin
        sq    = '0;
        level = '0;
        for (int i = 0; i < NCH; i++) begin
            sq[i] = phase_q[i] < (period_q[i] >> 1);
            if (state_q[i] == PLAY && sq[i]) begin
                level = level + LW'(1);
            end
        end
    end

    // Next-state logic: commands take priority over phase/duration updates.
    always_comb begin
        tick       = (tick_cnt_q == TW'(TICK_DIV - 1));
        tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);
        pwm_cnt_d  = pwm_cnt_q + PWM_BITS'(1);
        level_d    = (pwm_cnt_q == '0) ? level : level_q;
        aud_d      = (CMPW'(pwm_cnt_q) << NB) < (CMPW'(level_q) << PWM_BITS);
        wr_ok      = wr_en && (32'(wr_ch) < NCH);
        timed_d    = timed_q;
        done_d     = '0;
        for (int i = 0; i < NCH; i++) begin
            state_d[i]  = state_q[i];
            period_d[i] = period_q[i];
            phase_d[i]  = phase_q[i];
            dur_d[i]    = dur_q[i];
            if (wr_ok && wr_ch == CW'(i)) begin
                if (wr_period == '0) begin
                    state_d[i] = IDLE;
                end else begin
                    state_d[i]  = PLAY;
                    period_d[i] = wr_period;
                    phase_d[i]  = '0;
                    dur_d[i]    = wr_dur;
                    timed_d[i]  = (wr_dur != '0);
                end
            end else if (state_q[i] == PLAY) begin
                phase_d[i] = (phase_q[i] == period_q[i] - PW'(1)) ? '0 : phase_q[i] + PW'(1);
                if (tick && timed_q[i]) begin
                    dur_d[i] = dur_q[i] - DW'(1);
                    if (dur_q[i] == DW'(1)) begin
                        state_d[i] = IDLE;
                        done_d[i]  = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NCH; i++) begin
                state_q[i]  <= IDLE;
                period_q[i] <= '0;
                phase_q[i]  <= '0;
                dur_q[i]    <= '0;
            end
            timed_q    <= '0;
            done_q     <= '0;
            tick_cnt_q <= '0;
            pwm_cnt_q  <= '0;
            level_q    <= '0;
            aud_q      <= 1'b0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                state_q[i]  <= state_d[i];
                period_q[i] <= period_d[i];
                phase_q[i]  <= phase_d[i];
                dur_q[i]    <= dur_d[i];
            end
            timed_q    <= timed_d;
            done_q     <= done_d;
            tick_cnt_q <= tick_cnt_d;
            pwm_cnt_q  <= pwm_cnt_d;
            level_q    <= level_d;
            aud_q      <= aud_d;
        end
    end

    always_comb begin
        busy = '0;
        for (int i = 0; i < NCH; i++) begin
            busy[i] = (state_q[i] == PLAY);
        end
    end

    assign done   = done_q;
    assign audPWM = aud_q;

endmodule
